// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM state encoding,
// instruction opcodes, ALU operation selects, PC source encodings and an
// instruction legality helper. The ALU operation constants are also used by the ALU bench.
package cu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LATCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [3:0] ALU_PASS = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_REM  = 4'b1110;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // R-type funct codes 0000 and 1111 have no ALU operation and are treated
  // exactly like an unknown opcode.
  function automatic logic op_is_legal(input logic [5:0] opcode,
                                       input logic [3:0] funct);
    case (opcode)
      OP_RTYPE: return (funct != 4'b0000) && (funct != 4'b1111);
      OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J, OP_HALT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cu_watchdog.sv
// Memory-handshake watchdog. A down-counter is reloaded whenever the control
// FSM changes state and counts down on every cycle a memory request is left
// waiting. timeout is raised on the TIMEOUT_CYCLES-th consecutive wait cycle.
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : reload the counter (FSM is changing state)
//   waiting   : memory request outstanding and mem_ready low this cycle
//   timeout   : this wait cycle exhausts the budget
module cu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic waiting,
  output logic timeout
);
  import cu_pkg::*;

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt <= LOAD;
    else if (clear)   cnt <= LOAD;
    else if (waiting) cnt <= cnt - CW'(1);
  end

  // The FSM always leaves the waiting state on timeout, so the counter is
  // reloaded before it can wrap below zero.
  assign timeout = waiting && (cnt == '0);

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control FSM. Fetches through a ready-handshake memory port,
// decodes the instruction register and drives datapath enables, the ALU op
// select and PC source. Also counts retired instructions and faults into
// HALT if any memory request waits too long.
//   clk, rst     : clock, asynchronous active-high reset
//   instr        : instruction register contents (opcode [31:26], funct [3:0])
//   alu_zero     : ALU zero flag, used for the branch decision in EXEC
//   mem_ready    : memory completes the current access this cycle
//   cu_*         : datapath control outputs (zero while rst is high)
//   retired      : completed-instruction count, wraps to 0
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_FETCH  | read instruction at PC, wait for mem_ready
// ST_LATCH  | load IR, PC <= PC+4
// ST_DECODE | decode; J and HALT complete here, illegal returns to FETCH
// ST_EXEC   | ALU operation; branches resolve and complete here
// ST_MEM    | data access for LW/SW, wait for mem_ready
// ST_WB     | register write-back
// ST_HALT   | terminal; left only through rst
module multicycle_control_unit
  import cu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [3:0]       cu_aluOp,
  output logic             cu_aluSrc,
  output logic             cu_regDst,
  output logic             cu_memToReg,
  output logic             cu_regWrite,
  output logic             cu_memRead,
  output logic             cu_memWrite,
  output logic             cu_iorD,
  output logic             cu_irWrite,
  output logic             cu_pcWrite,
  output logic [1:0]       cu_pcSrc,
  output logic             cu_illegal,
  output logic             cu_fault,
  output logic             cu_halted,
  output logic [CNT_W-1:0] retired
);

  state_t     state_q, state_d;
  logic [5:0] opcode;
  logic [3:0] funct;
  logic       retire;
  logic       wd_wait;
  logic       wd_clear;
  logic       wd_timeout;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[3:0];
  assign unused_instr = ^instr[25:4];

  // Kept outside the FSM block so the watchdog's timeout can feed next-state
  // logic without forming a block-level combinational loop.
  assign wd_wait  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
  assign wd_clear = (state_d != state_q);

  cu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clear  (wd_clear),
    .waiting(wd_wait),
    .timeout(wd_timeout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             retired <= '0;
    else if (retire)     retired <= retired + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             cu_fault <= 1'b0;
    else if (wd_timeout) cu_fault <= 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    cu_aluOp    = ALU_PASS;
    cu_aluSrc   = 1'b0;
    cu_regDst   = 1'b0;
    cu_memToReg = 1'b0;
    cu_regWrite = 1'b0;
    cu_memRead  = 1'b0;
    cu_memWrite = 1'b0;
    cu_iorD     = 1'b0;
    cu_irWrite  = 1'b0;
    cu_pcWrite  = 1'b0;
    cu_pcSrc    = PC_SRC_SEQ;
    cu_illegal  = 1'b0;
    cu_halted   = 1'b0;

    // Outputs are gated by rst so nothing is issued during the reset cycle,
    // even though the reset state (FETCH) would otherwise request a read.
    if (!rst) begin
      unique case (state_q)
        ST_FETCH: begin
          cu_memRead = 1'b1;
          if (wd_timeout)     state_d = ST_HALT;
          else if (mem_ready) state_d = ST_LATCH;
        end
        ST_LATCH: begin
          cu_irWrite = 1'b1;
          cu_pcWrite = 1'b1;
          cu_pcSrc   = PC_SRC_SEQ;
          state_d    = ST_DECODE;
        end
        ST_DECODE: begin
          if (!op_is_legal(opcode, funct)) begin
            cu_illegal = 1'b1;
            state_d    = ST_FETCH;
          end else if (opcode == OP_J) begin
            cu_pcWrite = 1'b1;
            cu_pcSrc   = PC_SRC_JUMP;
            retire     = 1'b1;
            state_d    = ST_FETCH;
          end else if (opcode == OP_HALT) begin
            retire  = 1'b1;
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              cu_aluOp = funct;
              state_d  = ST_WB;
            end
            OP_ADDI: begin
              cu_aluOp  = ALU_ADD;
              cu_aluSrc = 1'b1;
              state_d   = ST_WB;
            end
            OP_LW, OP_SW: begin
              cu_aluOp  = ALU_ADD;
              cu_aluSrc = 1'b1;
              state_d   = ST_MEM;
            end
            OP_BEQ, OP_BNE: begin
              cu_aluOp   = ALU_SUB;
              cu_pcSrc   = PC_SRC_BRANCH;
              cu_pcWrite = (opcode == OP_BEQ) ? alu_zero : !alu_zero;
              retire     = 1'b1;
              state_d    = ST_FETCH;
            end
            default: state_d = ST_FETCH;
          endcase
        end
        ST_MEM: begin
          cu_iorD = 1'b1;
          if (opcode == OP_SW) cu_memWrite = 1'b1;
          else                 cu_memRead  = 1'b1;
          if (wd_timeout) begin
            state_d = ST_HALT;
          end else if (mem_ready) begin
            if (opcode == OP_SW) begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end
        end
        ST_WB: begin
          cu_regWrite = 1'b1;
          cu_regDst   = (opcode == OP_RTYPE);
          cu_memToReg = (opcode == OP_LW);
          retire      = 1'b1;
          state_d     = ST_FETCH;
        end
        ST_HALT: begin
          cu_halted = 1'b1;
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit. Each stimulus cycle pushes the
// hand-computed control vector and retired count into a scoreboard queue;
// a monitor pops and compares on every falling edge outside reset.
module tb_multicycle_control_unit;
  import cu_pkg::*;

  localparam int CNT_W = 4;

  // ctl vector layout: {aluOp[3:0], aluSrc, regDst, memToReg, regWrite,
  //                     memRead, memWrite, iorD, irWrite, pcWrite,
  //                     pcSrc[1:0], illegal, fault, halted}
  localparam logic [17:0] E_NONE   = 18'h00000;
  localparam logic [17:0] E_FETCH  = 18'h00200; // memRead
  localparam logic [17:0] E_LATCH  = 18'h00060; // irWrite, pcWrite, pcSrc 00
  localparam logic [17:0] E_JUMP   = 18'h00030; // pcWrite, pcSrc 10
  localparam logic [17:0] E_ILL    = 18'h00004; // illegal
  localparam logic [17:0] E_EX_ADD = 18'h04000; // aluOp 0001, aluSrc 0
  localparam logic [17:0] E_EX_REM = 18'h38000; // aluOp 1110, aluSrc 0
  localparam logic [17:0] E_EX_IMM = 18'h06000; // aluOp 0001, aluSrc 1
  localparam logic [17:0] E_BR_TK  = 18'h08028; // aluOp 0010, pcWrite, pcSrc 01
  localparam logic [17:0] E_BR_NT  = 18'h08008; // aluOp 0010, pcSrc 01
  localparam logic [17:0] E_MEM_LW = 18'h00280; // memRead, iorD
  localparam logic [17:0] E_MEM_SW = 18'h00180; // memWrite, iorD
  localparam logic [17:0] E_WB_R   = 18'h01400; // regWrite, regDst
  localparam logic [17:0] E_WB_I   = 18'h00400; // regWrite
  localparam logic [17:0] E_WB_LW  = 18'h00C00; // regWrite, memToReg
  localparam logic [17:0] E_HALT   = 18'h00001;
  localparam logic [17:0] E_HALT_F = 18'h00003; // halted + fault

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [31:0]      instr;
  logic             alu_zero;
  logic             mem_ready;
  logic [3:0]       cu_aluOp;
  logic             cu_aluSrc, cu_regDst, cu_memToReg, cu_regWrite;
  logic             cu_memRead, cu_memWrite, cu_iorD, cu_irWrite, cu_pcWrite;
  logic [1:0]       cu_pcSrc;
  logic             cu_illegal, cu_fault, cu_halted;
  logic [CNT_W-1:0] retired;
  logic [17:0]      ctl_now;

  multicycle_control_unit #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .cu_aluOp(cu_aluOp), .cu_aluSrc(cu_aluSrc), .cu_regDst(cu_regDst),
    .cu_memToReg(cu_memToReg), .cu_regWrite(cu_regWrite), .cu_memRead(cu_memRead),
    .cu_memWrite(cu_memWrite), .cu_iorD(cu_iorD), .cu_irWrite(cu_irWrite),
    .cu_pcWrite(cu_pcWrite), .cu_pcSrc(cu_pcSrc), .cu_illegal(cu_illegal),
    .cu_fault(cu_fault), .cu_halted(cu_halted), .retired(retired)
  );

  assign ctl_now = {cu_aluOp, cu_aluSrc, cu_regDst, cu_memToReg, cu_regWrite,
                    cu_memRead, cu_memWrite, cu_iorD, cu_irWrite, cu_pcWrite,
                    cu_pcSrc, cu_illegal, cu_fault, cu_halted};

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0]      ctl;
    logic [CNT_W-1:0] ret;
    string            name;
  } exp_t;

  exp_t             sb[$];
  int               errors = 0;
  int               checks = 0;
  logic [CNT_W-1:0] r = '0;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [3:0] fn);
    return {op, 22'd0, fn};
  endfunction

  // Monitor: compare one scoreboard entry per falling edge outside reset.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (ctl_now !== e.ctl) begin
          errors++;
          $display("FAIL %s ctl got %h expected %h", e.name, ctl_now, e.ctl);
        end
        checks++;
        if (retired !== e.ret) begin
          errors++;
          $display("FAIL %s retired got %0d expected %0d", e.name, retired, e.ret);
        end
      end
    end
  end

  task automatic cyc(input logic mr, input logic az, input logic [17:0] ctl,
                     input string nm);
    exp_t x;
    mem_ready = mr;
    alu_zero  = az;
    x.ctl  = ctl;
    x.ret  = r;
    x.name = nm;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic front(input string nm);
    cyc(1'b1, 1'b0, E_FETCH, {nm, "_fetch"});
    cyc(1'b1, 1'b0, E_LATCH, {nm, "_latch"});
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1, "simulation time limit");
  end

  initial begin
    instr     = mk(OP_RTYPE, 4'b0001);
    alu_zero  = 1'b0;
    mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", 32'(ctl_now), 32'h0);
    chk("reset_retired", 32'(retired), 32'h0);
    rst = 1'b0;

    // R-type ADD: 5 cycles
    instr = mk(OP_RTYPE, 4'b0001);
    front("add");
    cyc(1'b1, 1'b0, E_NONE, "add_decode");
    cyc(1'b1, 1'b0, E_EX_ADD, "add_exec");
    cyc(1'b1, 1'b0, E_WB_R, "add_wb");
    r = r + 1'b1;

    // ADDI: 5 cycles
    instr = mk(OP_ADDI, 4'b0000);
    front("addi");
    cyc(1'b1, 1'b0, E_NONE, "addi_decode");
    cyc(1'b1, 1'b0, E_EX_IMM, "addi_exec");
    cyc(1'b1, 1'b0, E_WB_I, "addi_wb");
    r = r + 1'b1;

    // LW with three MEM wait cycles: 9 cycles
    instr = mk(OP_LW, 4'b0000);
    front("lw");
    cyc(1'b1, 1'b0, E_NONE, "lw_decode");
    cyc(1'b1, 1'b0, E_EX_IMM, "lw_exec");
    cyc(1'b0, 1'b0, E_MEM_LW, "lw_mem_w1");
    cyc(1'b0, 1'b0, E_MEM_LW, "lw_mem_w2");
    cyc(1'b0, 1'b0, E_MEM_LW, "lw_mem_w3");
    cyc(1'b1, 1'b0, E_MEM_LW, "lw_mem_rdy");
    cyc(1'b1, 1'b0, E_WB_LW, "lw_wb");
    r = r + 1'b1;

    // SW with one FETCH wait cycle
    instr = mk(OP_SW, 4'b0000);
    cyc(1'b0, 1'b0, E_FETCH, "sw_fetch_wait");
    front("sw");
    cyc(1'b1, 1'b0, E_NONE, "sw_decode");
    cyc(1'b1, 1'b0, E_EX_IMM, "sw_exec");
    cyc(1'b1, 1'b0, E_MEM_SW, "sw_mem");
    r = r + 1'b1;

    // Branches: pcWrite follows alu_zero (BEQ) or its inverse (BNE)
    instr = mk(OP_BEQ, 4'b0000);
    front("beq_z1");
    cyc(1'b1, 1'b0, E_NONE, "beq_z1_decode");
    cyc(1'b1, 1'b1, E_BR_TK, "beq_z1_exec");
    r = r + 1'b1;
    instr = mk(OP_BNE, 4'b0000);
    front("bne_z1");
    cyc(1'b1, 1'b0, E_NONE, "bne_z1_decode");
    cyc(1'b1, 1'b1, E_BR_NT, "bne_z1_exec");
    r = r + 1'b1;
    front("bne_z0");
    cyc(1'b1, 1'b0, E_NONE, "bne_z0_decode");
    cyc(1'b1, 1'b0, E_BR_TK, "bne_z0_exec");
    r = r + 1'b1;
    instr = mk(OP_BEQ, 4'b0000);
    front("beq_z0");
    cyc(1'b1, 1'b0, E_NONE, "beq_z0_decode");
    cyc(1'b1, 1'b0, E_BR_NT, "beq_z0_exec");
    r = r + 1'b1;

    // Illegal opcode and illegal funct: one pulse each, no retirement
    instr = mk(6'b010101, 4'b0001);
    front("ill_op");
    cyc(1'b1, 1'b0, E_ILL, "ill_op_decode");
    instr = mk(OP_RTYPE, 4'b1111);
    front("ill_fn");
    cyc(1'b1, 1'b0, E_ILL, "ill_fn_decode");

    // Highest legal funct
    instr = mk(OP_RTYPE, ALU_REM);
    front("rem");
    cyc(1'b1, 1'b0, E_NONE, "rem_decode");
    cyc(1'b1, 1'b0, E_EX_REM, "rem_exec");
    cyc(1'b1, 1'b0, E_WB_R, "rem_wb");
    r = r + 1'b1;

    // Async reset in the middle of a SW data access
    instr = mk(OP_SW, 4'b0000);
    front("swrst");
    cyc(1'b1, 1'b0, E_NONE, "swrst_decode");
    cyc(1'b1, 1'b0, E_EX_IMM, "swrst_exec");
    begin
      exp_t x;
      mem_ready = 1'b0;
      x.ctl = E_MEM_SW; x.ret = r; x.name = "swrst_mem";
      sb.push_back(x);
    end
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_async_memwrite", 32'(cu_memWrite), 32'h0);
    chk("rst_async_ctl", 32'(ctl_now), 32'h0);
    chk("rst_async_retired", 32'(retired), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r   = '0;

    // 16 jumps: retired climbs to all-ones, then wraps to 0
    instr = mk(OP_J, 4'b0000);
    for (int i = 0; i < 16; i++) begin
      front("jmp");
      cyc(1'b1, 1'b0, E_JUMP, "jmp_decode");
      r = r + 1'b1;
    end

    // Watchdog: four FETCH wait cycles, then HALT with fault
    instr = mk(OP_RTYPE, 4'b0001);
    cyc(1'b0, 1'b0, E_FETCH, "wd_wait1");
    cyc(1'b0, 1'b0, E_FETCH, "wd_wait2");
    cyc(1'b0, 1'b0, E_FETCH, "wd_wait3");
    cyc(1'b0, 1'b0, E_FETCH, "wd_wait4");
    cyc(1'b0, 1'b0, E_HALT_F, "wd_halt");
    cyc(1'b1, 1'b0, E_HALT_F, "wd_halt_hold");
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_clears_fault", 32'(cu_fault), 32'h0);
    chk("rst_clears_halted", 32'(cu_halted), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    r   = '0;

    // HALT opcode retires and parks the FSM
    instr = mk(OP_HALT, 4'b0000);
    front("halt_op");
    cyc(1'b1, 1'b0, E_NONE, "halt_op_decode");
    r = r + 1'b1;
    cyc(1'b1, 1'b0, E_HALT, "halt_op_halted");
    cyc(1'b1, 1'b0, E_HALT, "halt_op_hold");

    @(negedge clk);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
